// File: rtl/music_seq.sv
// music_seq: playback sequencer for the note RAM.
// After reset it scans the RAM for the end-of-song byte to derive music_len.
// It then steps ram_addr_out through the song at STEP_HZ notes per second
// under play/pause/restart control.
module music_seq #(
    parameter int         CLK_HZ   = 100_000_000,
    parameter int         STEP_HZ  = 4,
    parameter logic [7:0] END_CODE = 8'hFF
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        play_toggle,
    input  logic        restart,
    output logic [11:0] ram_rd_addr,
    input  logic [7:0]  ram_rd_data,
    output logic [11:0] ram_addr_out,
    output logic [11:0] music_len,
    output logic [7:0]  note_code,
    output logic        note_valid,
    output logic        playing,
    output logic        scan_done
);
    // DIV must be at least 4 so that a new tick never overlaps a fetch in flight.
    localparam int DIV = CLK_HZ / STEP_HZ;
    localparam int PW  = $clog2(DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    localparam logic [2:0] SCAN_RD  = 3'd0;
    localparam logic [2:0] SCAN_CHK = 3'd1;
    localparam logic [2:0] IDLE     = 3'd2;
    localparam logic [2:0] PLAY     = 3'd3;
    localparam logic [2:0] DONE     = 3'd4;

    logic [2:0]    state_reg, state_next, base_state;
    logic [11:0]   rd_addr_reg, rd_addr_next;
    logic [11:0]   len_reg, len_next;
    logic          scan_done_reg, scan_done_next;
    logic [11:0]   addr_reg, addr_next, addr_inc;
    logic [7:0]    code_reg, code_next;
    logic          valid_reg, valid_next;
    logic [PW-1:0] presc_reg, presc_next;
    logic          e1_reg, e1_next;   // fetch address issued, RAM reading
    logic          e2_reg, e2_next;   // RAM data valid, emit this cycle
    logic          song_end;

    assign addr_inc = addr_reg + 12'd1;
    // The last note's completion ends the song, unless a restart overrides it.
    assign song_end = e2_reg && !restart && (addr_inc == len_reg);

    // Next-state logic: length scan, prescaler, fetch pipeline and play control.
    always_comb begin
        state_next     = state_reg;
        base_state     = state_reg;
        rd_addr_next   = rd_addr_reg;
        len_next       = len_reg;
        scan_done_next = scan_done_reg;
        addr_next      = addr_reg;
        code_next      = code_reg;
        valid_next     = 1'b0;
        presc_next     = presc_reg;
        e1_next        = 1'b0;
        e2_next        = 1'b0;
        case (state_reg)
            SCAN_RD: begin
                state_next = SCAN_CHK;
            end
            SCAN_CHK: begin
                if (ram_rd_data == END_CODE) begin
                    len_next       = rd_addr_reg;
                    scan_done_next = 1'b1;
                    state_next     = IDLE;
                end else if (rd_addr_reg == 12'hFFF) begin
                    len_next       = 12'hFFF;
                    scan_done_next = 1'b1;
                    state_next     = IDLE;
                end else begin
                    rd_addr_next = rd_addr_reg + 12'd1;
                    state_next   = SCAN_RD;
                end
            end
            default: begin
                // A fetch in flight completes whatever the play state is.
                if (e2_reg) begin
                    code_next  = ram_rd_data;
                    valid_next = 1'b1;
                    addr_next  = addr_inc;
                end
                e2_next = e1_reg;
                if (state_reg == PLAY) begin
                    presc_next = (presc_reg == PRESC_LAST) ? '0 : presc_reg + PW'(1);
                    if (presc_reg == '0) begin
                        rd_addr_next = addr_reg;
                        e1_next      = 1'b1;
                    end
                end
                // Restart is applied first; the toggle then acts on the result.
                if (restart) begin
                    addr_next  = 12'd0;
                    presc_next = '0;
                    code_next  = code_reg;
                    valid_next = 1'b0;
                    e1_next    = 1'b0;
                    e2_next    = 1'b0;
                    base_state = (state_reg == DONE) ? IDLE : state_reg;
                end
                state_next = base_state;
                if (song_end) begin
                    state_next = DONE;
                end else if (play_toggle) begin
                    case (base_state)
                        IDLE: if (len_reg != 12'd0) state_next = PLAY;
                        PLAY: state_next = IDLE;
                        DONE: begin
                            addr_next  = 12'd0;
                            presc_next = '0;
                            state_next = PLAY;
                        end
                        default: state_next = base_state;
                    endcase
                end
            end
        endcase
    end

    // State registers; asynchronous reset restarts the length scan.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg     <= SCAN_RD;
            rd_addr_reg   <= 12'd0;
            len_reg       <= 12'd0;
            scan_done_reg <= 1'b0;
            addr_reg      <= 12'd0;
            code_reg      <= 8'd0;
            valid_reg     <= 1'b0;
            presc_reg     <= '0;
            e1_reg        <= 1'b0;
            e2_reg        <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rd_addr_reg   <= rd_addr_next;
            len_reg       <= len_next;
            scan_done_reg <= scan_done_next;
            addr_reg      <= addr_next;
            code_reg      <= code_next;
            valid_reg     <= valid_next;
            presc_reg     <= presc_next;
            e1_reg        <= e1_next;
            e2_reg        <= e2_next;
        end
    end

    assign ram_rd_addr  = rd_addr_reg;
    assign ram_addr_out = addr_reg;
    assign music_len    = len_reg;
    assign note_code    = code_reg;
    assign note_valid   = valid_reg;
    assign scan_done    = scan_done_reg;
    assign playing      = (state_reg == PLAY);
endmodule

// File: tb/tb_music_seq.sv
// tb_music_seq: directed test of music_seq with DIV = 10 and a behavioural note RAM.
module tb_music_seq;
    logic        sys_clk;
    logic        sys_rst_n;
    logic        play_toggle;
    logic        restart;
    logic [11:0] ram_rd_addr;
    logic [7:0]  ram_rd_data;
    logic [11:0] ram_addr_out;
    logic [11:0] music_len;
    logic [7:0]  note_code;
    logic        note_valid;
    logic        playing;
    logic        scan_done;

    logic [7:0] mem [4096];
    int checks = 0;
    int errors = 0;

    music_seq #(.CLK_HZ(40), .STEP_HZ(4), .END_CODE(8'hFF)) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .play_toggle  (play_toggle),
        .restart      (restart),
        .ram_rd_addr  (ram_rd_addr),
        .ram_rd_data  (ram_rd_data),
        .ram_addr_out (ram_addr_out),
        .music_len    (music_len),
        .note_code    (note_code),
        .note_valid   (note_valid),
        .playing      (playing),
        .scan_done    (scan_done)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Synchronous note RAM with one cycle of read latency.
    always @(posedge sys_clk) ram_rd_data <= mem[ram_rd_addr];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("check %s = %0d", tag, got);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    // Step until a note strobe (bounded) and check the number of edges taken.
    task automatic wait_note(input string tag, input int exp_gap);
        int  n;
        bit  seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            step();
            n++;
            if (note_valid) seen = 1'b1;
        end
        check_eq({tag, "_gap"}, n, exp_gap);
        $display("note %s: code=%0d addr=%0d playing=%0d", tag, note_code, ram_addr_out, playing);
    endtask

    task automatic count_strobes(input int n, output int strobes);
        strobes = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (note_valid) strobes++;
        end
    endtask

    task automatic pulse_toggle();
        play_toggle = 1'b1;
        step();
        play_toggle = 1'b0;
    endtask

    initial begin
        int s;
        sys_rst_n   = 1'b0;
        play_toggle = 1'b0;
        restart     = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[0] = 8'd10; mem[1] = 8'd11; mem[2] = 8'd12; mem[3] = 8'hFF;

        // Reset state
        step(); step();
        check_eq("rst_scan_done", scan_done, 0);
        check_eq("rst_addr_out", ram_addr_out, 0);
        check_eq("rst_valid", note_valid, 0);

        // Length scan: terminator at 3 -> done after edge 8
        sys_rst_n = 1'b1;
        repeat (7) step();
        check_eq("scan_e7_done", scan_done, 0);
        step();
        check_eq("scan_e8_done", scan_done, 1);
        check_eq("scan_len", music_len, 3);
        check_eq("scan_playing", playing, 0);

        // Play straight through the song
        pulse_toggle();
        check_eq("play_playing", playing, 1);
        wait_note("n1", 3);
        check_eq("n1_code", note_code, 10);
        check_eq("n1_addr", ram_addr_out, 1);
        wait_note("n2", 10);
        check_eq("n2_code", note_code, 11);
        check_eq("n2_addr", ram_addr_out, 2);
        wait_note("n3", 10);
        check_eq("n3_code", note_code, 12);
        check_eq("n3_addr", ram_addr_out, 3);
        check_eq("n3_playing", playing, 0);
        count_strobes(25, s);
        check_eq("done_quiet", s, 0);

        // Toggle from DONE replays from address 0
        pulse_toggle();
        check_eq("replay_addr", ram_addr_out, 0);
        check_eq("replay_playing", playing, 1);
        wait_note("r1", 3);
        check_eq("r1_code", note_code, 10);
        check_eq("r1_addr", ram_addr_out, 1);

        // Pause 4 cycles after the strobe, wait, resume
        repeat (3) step();
        pulse_toggle();
        check_eq("pause_playing", playing, 0);
        count_strobes(50, s);
        check_eq("pause_quiet", s, 0);
        check_eq("pause_addr", ram_addr_out, 1);
        pulse_toggle();
        wait_note("r2", 6);
        check_eq("r2_code", note_code, 11);
        check_eq("r2_addr", ram_addr_out, 2);

        // Restart and toggle together in PLAY -> IDLE at address 0
        restart = 1'b1;
        play_toggle = 1'b1;
        step();
        restart = 1'b0;
        play_toggle = 1'b0;
        check_eq("rt_addr", ram_addr_out, 0);
        check_eq("rt_playing", playing, 0);
        check_eq("rt_valid", note_valid, 0);
        count_strobes(30, s);
        check_eq("rt_quiet", s, 0);

        // Restart coinciding with the emit edge cancels the note
        pulse_toggle();
        step(); step();
        restart = 1'b1;
        step();
        restart = 1'b0;
        check_eq("rs_e2_valid", note_valid, 0);
        check_eq("rs_e2_addr", ram_addr_out, 0);
        check_eq("rs_e2_playing", playing, 1);
        wait_note("rs1", 3);
        check_eq("rs1_code", note_code, 10);
        check_eq("rs1_addr", ram_addr_out, 1);

        // Asynchronous reset mid-PLAY clears outputs without a clock edge
        sys_rst_n = 1'b0;
        #2;
        check_eq("arst_code", note_code, 0);
        check_eq("arst_addr", ram_addr_out, 0);
        check_eq("arst_len", music_len, 0);
        check_eq("arst_playing", playing, 0);
        check_eq("arst_done", scan_done, 0);

        // Empty song: music_len 0, play ignored
        mem[0] = 8'hFF;
        step();
        sys_rst_n = 1'b1;
        step();
        check_eq("empty_e1_done", scan_done, 0);
        step();
        check_eq("empty_e2_done", scan_done, 1);
        check_eq("empty_len", music_len, 0);
        pulse_toggle();
        check_eq("empty_playing", playing, 0);
        count_strobes(20, s);
        check_eq("empty_quiet", s, 0);

        // No terminator anywhere: music_len 4095 after edge 8192
        sys_rst_n = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'(i % 200);
        step();
        sys_rst_n = 1'b1;
        repeat (8191) step();
        check_eq("full_e8191_done", scan_done, 0);
        step();
        check_eq("full_e8192_done", scan_done, 1);
        check_eq("full_len", music_len, 4095);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/music_seq.md
# music_seq

Playback sequencer that sits directly upstream of the time display stage. After reset it scans the note RAM for the end-of-song code and derives `music_len`. On a play command it steps `ram_addr_out` through the song at `STEP_HZ` addresses per second, emitting one note per step. The display stage converts `ram_addr_out` and `music_len` into mm:ss, treating 4 addresses as 1 s, so the default `STEP_HZ` is 4.

## Interface
- `CLK_HZ`, 100_000_000: system clock frequency.
- `STEP_HZ`, 4: address steps per second. DIV = CLK_HZ/STEP_HZ, and DIV must be ≥ 4.
- `END_CODE`, 8'hFF: RAM byte that marks the end of the song.
- `sys_clk`  in  1  system clock.
- `sys_rst_n`  in  1  asynchronous, active-low reset.
- `play_toggle`  in  1  one-cycle pulse; toggles play/pause.
- `restart`  in  1  one-cycle pulse; returns playback to address 0.
- `ram_rd_addr`  out  12  note RAM read address. The RAM is synchronous with 1-cycle read latency.
- `ram_rd_data`  in  8  note RAM read data.
- `ram_addr_out`  out  12  address of the next note; feeds the time display.
- `music_len`  out  12  song length in addresses; feeds the time display.
- `note_code`  out  8  last note played.
- `note_valid`  out  1  one-cycle strobe when `note_code` updates.
- `playing`  out  1  high while in PLAY.
- `scan_done`  out  1  high once `music_len` is valid; remains high until reset.

## Operation
- Reset values: all outputs 0, prescaler 0, state SCAN_RD.
- States: SCAN_RD, SCAN_CHK, IDLE, PLAY, DONE.
- SCAN_RD: always moves to SCAN_CHK. The RAM latches `ram_rd_addr` on this edge.
- SCAN_CHK, when `ram_rd_data` == `END_CODE`:
  - `music_len` <= `ram_rd_addr`;
  - `scan_done` <= 1;
  - go to IDLE.
- SCAN_CHK, when `ram_rd_addr` == 4095 with no terminator found:
  - `music_len` <= 4095;
  - `scan_done` <= 1;
  - go to IDLE.
- SCAN_CHK, otherwise: `ram_rd_addr` + 1, go to SCAN_RD.
- During scan, `play_toggle` and `restart` are ignored.
- IDLE (paused):
  - `play_toggle` goes to PLAY.
  - If `music_len` == 0, `play_toggle` is ignored.
- PLAY prescaler:
  - Increments every PLAY cycle.
  - Wraps from DIV-1 to 0.
  - Holds its value in IDLE, so a resume continues the partial period.
- PLAY tick: a tick occurs on any PLAY cycle with prescaler == 0, so the first note follows immediately after play from a fresh start.
- Note fetch pipeline (3 edges, runs alongside the prescaler):
  - E0, tick edge: `ram_rd_addr` <= `ram_addr_out`.
  - E1: RAM read.
  - E2: `note_code` <= `ram_rd_data`, `note_valid` <= 1 for 1 cycle, `ram_addr_out` <= `ram_addr_out` + 1.
- End of song: if the incremented address equals `music_len` at E2, go to DONE and `playing` <= 0 on that same edge.
- `play_toggle` in PLAY goes to IDLE. A fetch already in flight still completes E2 and its note is emitted.
- DONE: `play_toggle` sets `ram_addr_out` <= 0 and prescaler <= 0, then goes to PLAY.
- `restart` in IDLE, PLAY or DONE:
  - `ram_addr_out` <= 0 and prescaler <= 0;
  - any in-flight fetch is cancelled, with no `note_valid`;
  - PLAY stays in PLAY, IDLE stays in IDLE, DONE goes to IDLE.
- `restart` and `play_toggle` in the same cycle: apply the restart first, then the toggle from the resulting state. Example: PLAY goes to IDLE at address 0.
- `restart` coinciding with E2: the restart wins. `ram_addr_out` = 0 and `note_valid` stays 0.
- Reset mid-operation is asynchronous. All state and outputs return to reset values and the length scan reruns.

## Timing
- Scan: 2 cycles per address. A terminator at address L gives `scan_done` = 1 after edge 2(L+1) following reset release.
- Step period in PLAY: exactly DIV cycles between `note_valid` strobes, including across a pause/resume (excluding paused cycles).
- Latency: `note_valid` goes high 2 cycles after the tick edge. `ram_addr_out` and `note_code` change on the same edge as `note_valid`.
- `playing` falls on the same edge that `ram_addr_out` reaches `music_len`.
- `play_toggle` pulses are sampled every cycle, with no debounce inside this block.

## Test plan
- RAM = {10,11,12,FF}, reset released → `scan_done` = 1 after edge 8; `music_len` = 3; `playing` = 0.
- Same RAM, CLK_HZ = 40, STEP_HZ = 4 (DIV = 10), then `play_toggle` → `note_valid` strobes 10 cycles apart with `note_code` 10, 11, 12 and `ram_addr_out` 1, 2, 3; `playing` falls with the third strobe; DONE.
- Pause 4 cycles after the first strobe, wait 50 cycles, resume → the second strobe arrives 6 PLAY cycles after resume; `ram_addr_out` holds at 1 while paused.
- In PLAY at address 2, pulse `restart` and `play_toggle` together → `ram_addr_out` = 0, state IDLE, no `note_valid`.
- RAM with no FF byte anywhere → `music_len` = 4095, `scan_done` after edge 8192.
- RAM[0] = FF → `music_len` = 0; `play_toggle` is ignored and `playing` stays 0. Assert reset mid-PLAY → all outputs 0 immediately.
